// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and types
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Bubble word: decodes as sll $0,$0,0, harmless since $0 is hardwired
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } if_state_t;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with hold, bubble and load controls
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // Bubble beats hold beats load; with no control asserted the contents stay
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bubble) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (hold) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (load) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end
  end

  // Register update with synchronous reset to an empty bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS fetch stage with PC, next-PC mux and IF/ID register (option: IF_STAGE_FETCH_COUNT_EN)
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_n,
  input  logic [25:0]       jump_index,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid,
`ifdef IF_STAGE_FETCH_COUNT_EN
  output logic [31:0]       fetch_count,
`endif
  output logic [5:0]        opcode
);

  if_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic              fetch_done;
  logic              ifid_hold, ifid_bubble, ifid_load;

  assign imem_addr  = pc_q;
  assign pc_plus4   = pc_q + 32'd4;
  assign fetch_done = imem_req & imem_ready;

  // FSM next state and fetch request: one idle boot cycle, then fetch forever
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  // Next PC and IF/ID control: branch (older) > jump > stall > fetch > wait
  always_comb begin
    pc_d        = pc_q;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_load   = 1'b0;
    if (branch_taken) begin
      pc_d        = branch_target;
      ifid_bubble = 1'b1;
    end else if (!jump_n) begin
      pc_d        = {ifid_pc4[31:28], jump_index, 2'b00};
      ifid_bubble = 1'b1;
    end else if (stall) begin
      ifid_hold   = 1'b1;
    end else if (fetch_done) begin
      pc_d        = pc_plus4;
      ifid_load   = 1'b1;
    end else begin
      ifid_bubble = 1'b1;
    end
  end

  // PC and FSM state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifid_reg u_ifid_reg (
    .clk      (clk),
    .reset    (reset),
    .hold     (ifid_hold),
    .bubble   (ifid_bubble),
    .load     (ifid_load),
    .instr_in (imem_rdata),
    .pc4_in   (pc_plus4),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4),
    .valid    (ifid_valid)
  );

  assign opcode = ifid_instr[31:26];

`ifdef IF_STAGE_FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // Count only fetches that actually land in IF/ID
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (ifid_load) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // Fetch counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_n;
  logic [25:0] jump_index;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  opcode;
`ifdef IF_STAGE_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int checks;
  int failures;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_n        (jump_n),
    .jump_index    (jump_index),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
`ifdef IF_STAGE_FETCH_COUNT_EN
    .fetch_count   (fetch_count),
`endif
    .opcode        (opcode)
  );

  // Memory model: each word is its address tagged with 0xA in the top nibble
  assign imem_rdata = 32'hA000_0000 | imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump_n = 1'b1; jump_index = 26'h0; imem_ready = 1'b1;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%08h exp=00000000", imem_addr); end
    checks++; if (ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b0 || opcode !== 6'h0) begin
      failures++; $display("FAIL rst_ifid got=%08h/%08h/%0h/%0h exp=0/0/0/0", ifid_instr, ifid_pc4, ifid_valid, opcode); end
`ifdef IF_STAGE_FETCH_COUNT_EN
    checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fetch_count); end
`endif
  endtask

  task automatic test_sequential();
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL boot_req got=%0h exp=0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ifid_valid !== 1'b0) begin
      failures++; $display("FAIL fetch0 got=%0h/%08h/%0h exp=1/00000000/0", imem_req, imem_addr, ifid_valid); end
    tick();
    checks++; if (imem_addr !== 32'h4 || ifid_pc4 !== 32'h4 || ifid_instr !== 32'hA000_0000 || ifid_valid !== 1'b1) begin
      failures++; $display("FAIL seq1 got=%08h/%08h/%08h/%0h exp=4/4/a0000000/1", imem_addr, ifid_pc4, ifid_instr, ifid_valid); end
    checks++; if (opcode !== 6'h28) begin failures++; $display("FAIL opcode got=%0h exp=28", opcode); end
    tick();
    checks++; if (imem_addr !== 32'h8 || ifid_pc4 !== 32'h8 || ifid_instr !== 32'hA000_0004) begin
      failures++; $display("FAIL seq2 got=%08h/%08h/%08h exp=8/8/a0000004", imem_addr, ifid_pc4, ifid_instr); end
  endtask

  task automatic test_wait();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 32'h8 || ifid_valid !== 1'b0 || imem_req !== 1'b1) begin
        failures++; $display("FAIL wait%0d got=%08h/%0h exp=8/0", i, imem_addr, ifid_valid); end
    end
    imem_ready = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'hC || ifid_pc4 !== 32'hC || ifid_instr !== 32'hA000_0008 || ifid_valid !== 1'b1) begin
      failures++; $display("FAIL wait_land got=%08h/%08h/%08h/%0h exp=c/c/a0000008/1", imem_addr, ifid_pc4, ifid_instr, ifid_valid); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (imem_addr !== 32'hC || ifid_pc4 !== 32'hC || ifid_instr !== 32'hA000_0008 || ifid_valid !== 1'b1) begin
        failures++; $display("FAIL stall%0d got=%08h/%08h/%08h/%0h exp=c/c/a0000008/1", i, imem_addr, ifid_pc4, ifid_instr, ifid_valid); end
    end
`ifdef IF_STAGE_FETCH_COUNT_EN
    checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", fetch_count); end
`endif
    stall = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h10 || ifid_pc4 !== 32'h10 || ifid_instr !== 32'hA000_000C) begin
      failures++; $display("FAIL unstall got=%08h/%08h/%08h exp=10/10/a000000c", imem_addr, ifid_pc4, ifid_instr); end
  endtask

  task automatic test_branch_priority();
    branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1; jump_n = 1'b0; jump_index = 26'h3FF;
    tick();
    checks++; if (imem_addr !== 32'h40 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
      failures++; $display("FAIL branch_prio got=%08h/%0h/%08h/%08h exp=40/0/0/0", imem_addr, ifid_valid, ifid_instr, ifid_pc4); end
    stall = 1'b0; jump_n = 1'b1;
    branch_target = 32'h42;
    tick();
    checks++; if (imem_addr !== 32'h42) begin failures++; $display("FAIL misalign got=%08h exp=42", imem_addr); end
    branch_taken = 1'b0;
  endtask

  task automatic test_jump();
    branch_taken = 1'b1; branch_target = 32'h1000_000C;
    tick();
    branch_taken = 1'b0;
    tick();
    checks++; if (ifid_pc4 !== 32'h1000_0010 || ifid_valid !== 1'b1) begin
      failures++; $display("FAIL jump_setup got=%08h/%0h exp=10000010/1", ifid_pc4, ifid_valid); end
    jump_n = 1'b0; jump_index = 26'h000_0100;
    tick();
    checks++; if (imem_addr !== 32'h1000_0400 || ifid_valid !== 1'b0) begin
      failures++; $display("FAIL jump got=%08h/%0h exp=10000400/0", imem_addr, ifid_valid); end
    jump_n = 1'b1;
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'hFFFF_FFFC || ifid_valid !== 1'b1) begin
      failures++; $display("FAIL wrap got=%08h/%08h/%08h/%0h exp=0/0/fffffffc/1", imem_addr, ifid_pc4, ifid_instr, ifid_valid); end
  endtask

  task automatic test_reset_mid_wait();
    branch_taken = 1'b1; branch_target = 32'h20;
    tick();
    branch_taken = 1'b0; imem_ready = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h20 || ifid_valid !== 1'b0) begin
      failures++; $display("FAIL pre_rst got=%08h/%0h exp=20/0", imem_addr, ifid_valid); end
    reset = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b0) begin
      failures++; $display("FAIL mid_rst got=%08h/%0h/%08h/%08h/%0h exp=0/0/0/0/0", imem_addr, imem_req, ifid_instr, ifid_pc4, ifid_valid); end
    reset = 1'b0; imem_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reboot_req got=%0h exp=0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL refetch got=%0h/%08h exp=1/0", imem_req, imem_addr); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sequential();
    test_wait();
    test_stall();
    test_branch_priority();
    test_jump();
    test_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
